// File: rtl/riscv_exec_pkg.sv
// Shared constants for the execution unit: ALU opcodes and the PC step.
// Codes 3..5 are decoded only when RISCV_EXEC_EXT_ALU_EN is defined.
package riscv_exec_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t AluAnd = 4'd0;
  localparam alu_op_t AluOr  = 4'd1;
  localparam alu_op_t AluAdd = 4'd2;
  localparam alu_op_t AluXor = 4'd3;
  localparam alu_op_t AluSll = 4'd4;
  localparam alu_op_t AluSrl = 4'd5;
  localparam alu_op_t AluSub = 4'd6;
  localparam alu_op_t AluSlt = 4'd7;
  localparam alu_op_t AluNor = 4'd12;

  localparam logic [31:0] PcIncr = 32'd4;

endpackage

// File: rtl/riscv_exec_alu.sv
// Combinational 32-bit ALU. Defining RISCV_EXEC_EXT_ALU_EN adds XOR, SLL and SRL;
// without it those codes fall through to zero like any other undefined code.
module riscv_exec_alu
  import riscv_exec_pkg::*;
(
  input  logic [3:0]  ctl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = 32'h0;
    case (ctl_i)
      AluAnd: result_o = a_i & b_i;
      AluOr:  result_o = a_i | b_i;
      AluAdd: result_o = a_i + b_i;
      AluSub: result_o = a_i - b_i;
      AluSlt: result_o = {31'h0, $signed(a_i) < $signed(b_i)};
      AluNor: result_o = ~(a_i | b_i);
`ifdef RISCV_EXEC_EXT_ALU_EN
      AluXor: result_o = a_i ^ b_i;
      AluSll: result_o = a_i << b_i[4:0];
      AluSrl: result_o = a_i >> b_i[4:0];
`endif
      default: result_o = 32'h0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/riscv_exec_unit.sv
// Execution slice: program counter, ALU and a word-addressed data memory.
// Extra ALU ops are enabled by RISCV_EXEC_EXT_ALU_EN (see riscv_exec_alu).
module riscv_exec_unit
  import riscv_exec_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcnext,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_reg,
  input  logic [3:0]  alu_ctl,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        zero,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] mem_d [MEM_WORDS];
  logic [IdxW-1:0] mem_idx;

  // Byte offset and out-of-range upper bits are deliberately ignored (wraparound).
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:IdxW+2], mem_addr[1:0]};

  assign mem_idx = mem_addr[IdxW+1:2];

  always_comb begin
    pc_d = pcnext ? pc_target : pc_q + PcIncr;
  end

  always_comb begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (mem_we) begin
      mem_d[mem_idx] = mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign pc_reg    = pc_q;
  assign mem_rdata = mem_re ? mem_q[mem_idx] : 32'h0;

  riscv_exec_alu u_alu (
    .ctl_i    (alu_ctl),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_out),
    .zero_o   (zero)
  );

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Directed self-checking bench for riscv_exec_unit: PC, ALU, memory and reset.
module tb_riscv_exec_unit;

  localparam int unsigned MemWords = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcnext;
  logic [31:0] pc_target;
  logic [31:0] pc_reg;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        zero;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  riscv_exec_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (MemWords)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pcnext    (pcnext),
    .pc_target (pc_target),
    .pc_reg    (pc_reg),
    .alu_ctl   (alu_ctl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .zero      (zero),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_ctl = c;
    alu_a   = a;
    alu_b   = b;
    #1;
  endtask

  initial begin
    reset = 1'b0; pcnext = 1'b0; pc_target = 32'h0;
    alu_ctl = 4'd0; alu_a = 32'h0; alu_b = 32'h0;
    mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;

    // Reset then sequential increment
    tick();
    check("pc_reset", pc_reg, 32'h0);
    reset = 1'b1;
    tick(); check("pc_inc1", pc_reg, 32'h4);
    tick(); check("pc_inc2", pc_reg, 32'h8);
    tick(); check("pc_inc3", pc_reg, 32'hC);

    // Reset overrides a pending branch
    reset = 1'b0; pcnext = 1'b1; pc_target = 32'h1234;
    tick(); check("pc_reset_over_branch", pc_reg, 32'h0);
    reset = 1'b1; pcnext = 1'b0;
    tick(); tick(); check("pc_at_8", pc_reg, 32'h8);

    // Branch then sequential
    pcnext = 1'b1; pc_target = 32'h40;
    tick(); check("pc_branch", pc_reg, 32'h40);
    pcnext = 1'b0;
    tick(); check("pc_after_branch", pc_reg, 32'h44);

    // PC wraps modulo 2^32
    pcnext = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick(); pcnext = 1'b0;
    tick(); check("pc_wrap", pc_reg, 32'h0);

    // ALU
    alu(4'd2, 32'd5, 32'd3);  check("alu_add", alu_out, 32'd8);
    alu(4'd6, 32'd5, 32'd3);  check("alu_sub", alu_out, 32'd2);
    alu(4'd0, 32'd5, 32'd3);  check("alu_and", alu_out, 32'd1);
    alu(4'd1, 32'd5, 32'd3);  check("alu_or", alu_out, 32'd7);
    check("alu_zero_clear", {31'h0, zero}, 32'd0);
    alu(4'd6, 32'd9, 32'd9);  check("alu_sub_eq", alu_out, 32'd0);
    check("alu_zero_set", {31'h0, zero}, 32'd1);
    alu(4'd7, 32'hFFFF_FFFF, 32'd1); check("alu_slt_neg", alu_out, 32'd1);
    alu(4'd7, 32'd1, 32'hFFFF_FFFF); check("alu_slt_pos", alu_out, 32'd0);
    alu(4'd12, 32'd0, 32'd0); check("alu_nor", alu_out, 32'hFFFF_FFFF);
    alu(4'd2, 32'hFFFF_FFFF, 32'd1); check("alu_add_wrap", alu_out, 32'd0);
    alu(4'd6, 32'd0, 32'd1);  check("alu_sub_wrap", alu_out, 32'hFFFF_FFFF);
    alu(4'd15, 32'd5, 32'd3); check("alu_undef", alu_out, 32'd0);
`ifdef RISCV_EXEC_EXT_ALU_EN
    alu(4'd3, 32'hF0F0, 32'h0FF0);   check("alu_xor", alu_out, 32'hFF00);
    alu(4'd4, 32'd1, 32'd4);         check("alu_sll", alu_out, 32'd16);
    alu(4'd5, 32'h8000_0000, 32'd35); check("alu_srl", alu_out, 32'h1000_0000);
`else
    alu(4'd3, 32'hF0F0, 32'h0FF0);   check("alu_xor_off", alu_out, 32'd0);
    alu(4'd4, 32'd1, 32'd4);         check("alu_sll_off", alu_out, 32'd0);
    alu(4'd5, 32'h8000_0000, 32'd3); check("alu_srl_off", alu_out, 32'd0);
`endif

    // Memory write with same-word read: old data before the edge, new after
    mem_we = 1'b1; mem_re = 1'b1; mem_addr = 32'd8; mem_wdata = 32'hDEAD_BEEF;
    #1; check("mem_old_before_edge", mem_rdata, 32'h0);
    tick(); check("mem_new_after_edge", mem_rdata, 32'hDEAD_BEEF);
    mem_we = 1'b0;
    mem_addr = 32'd11; #1; check("mem_byte_offset", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'd8 + 4 * MemWords; #1; check("mem_alias", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'd12; #1; check("mem_other_word", mem_rdata, 32'h0);
    mem_addr = 32'd8; mem_re = 1'b0; #1; check("mem_re_off", mem_rdata, 32'h0);

    // Write to addr 4, then reset clears it; a write during reset is dropped
    mem_we = 1'b1; mem_addr = 32'd4; mem_wdata = 32'h1234_5678;
    tick(); mem_we = 1'b0; mem_re = 1'b1;
    #1; check("mem_addr4", mem_rdata, 32'h1234_5678);
    reset = 1'b0; mem_we = 1'b1; mem_addr = 32'd16; mem_wdata = 32'hCAFE_F00D;
    tick(); reset = 1'b1; mem_we = 1'b0;
    #1; check("mem_write_in_reset", mem_rdata, 32'h0);
    mem_addr = 32'd4; #1; check("mem_reset_clear4", mem_rdata, 32'h0);
    mem_addr = 32'd8; #1; check("mem_reset_clear8", mem_rdata, 32'h0);
    check("pc_after_reset2", pc_reg, 32'h0);
    tick(); check("pc_first_after_reset", pc_reg, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
